// File: rtl/mem_stage_pipe_pkg.sv
// mem_stage_pipe_pkg: shared widths, register $0 and EX/MEM, MEM/WB field offsets for mem_stage_pipe.
package mem_stage_pipe_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    // EX/MEM vector: {MemWrite, MemtoReg, RegWrite, regwraddr, aluout, wrdata}
    localparam int EM_WD  = 0;
    localparam int EM_ALU = DATA_W;
    localparam int EM_RD  = 2 * DATA_W;
    localparam int EM_RW  = EM_RD + REG_AW;
    localparam int EM_M2R = EM_RW + 1;
    localparam int EM_MW  = EM_M2R + 1;
    localparam int EM_W   = EM_MW + 1;
    // control bits cleared by a flush bubble
    localparam logic [EM_W-1:0] EM_CTRL = {3'b111, {(EM_W-3){1'b0}}};
    // MEM/WB vector: {MemtoReg, RegWrite, regwraddr, aluout, memrddata}
    localparam int MW_RDD = 0;
    localparam int MW_ALU = DATA_W;
    localparam int MW_RD  = 2 * DATA_W;
    localparam int MW_RW  = MW_RD + REG_AW;
    localparam int MW_M2R = MW_RW + 1;
    localparam int MW_W   = MW_M2R + 1;
endpackage

// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: EX-side inputs, data-memory and WB signals of the MEM stage.
// master drives EX controls/data, forward select, DMrddata (and MEMstall when MEM_STALL_EN);
// slave is the stage itself and drives DM*, MEM* and WB* outputs.
interface mem_stage_pipe_if;
    import mem_stage_pipe_pkg::*;
`ifdef MEM_STALL_EN
    logic MEMstall;
`endif
    logic EXflush, EXMemWrite, EXMemtoReg, EXRegWrite;
    logic [REG_AW-1:0] EXregwraddr;
    logic [DATA_W-1:0] EXaluout, EXwrdata;
    logic pre_lw_and_curr_sw;
    logic [DATA_W-1:0] DMrddata, DMaddr, DMwrdata;
    logic DMwe, MEMMemWrite;
    logic [REG_AW-1:0] MEMregwraddr, WBregwraddr;
    logic WBMemtoReg, WBRegWrite;
    logic [DATA_W-1:0] WBmemrddata, WBaluout, WBwrbackdata;
    modport master (
`ifdef MEM_STALL_EN
        output MEMstall,
`endif
        output EXflush, EXMemWrite, EXMemtoReg, EXRegWrite, EXregwraddr, EXaluout, EXwrdata,
        output pre_lw_and_curr_sw, DMrddata,
        input DMaddr, DMwrdata, DMwe, MEMMemWrite, MEMregwraddr,
        input WBMemtoReg, WBRegWrite, WBregwraddr, WBmemrddata, WBaluout, WBwrbackdata
    );
    modport slave (
`ifdef MEM_STALL_EN
        input MEMstall,
`endif
        input EXflush, EXMemWrite, EXMemtoReg, EXRegWrite, EXregwraddr, EXaluout, EXwrdata,
        input pre_lw_and_curr_sw, DMrddata,
        output DMaddr, DMwrdata, DMwe, MEMMemWrite, MEMregwraddr,
        output WBMemtoReg, WBRegWrite, WBregwraddr, WBmemrddata, WBaluout, WBwrbackdata
    );
endinterface

// File: rtl/mem_stage_pipe_pipe_reg.sv
// pipe_reg: W-bit pipeline register, sync active-low reset, hold (i_en=0) and masked clear.
// Ports: clk, rst_n, i_en (advance), i_clr (zero the CLR_MASK bits of i_d), i_d, o_q.
module pipe_reg #(
    parameter int W = 8,
    parameter logic [W-1:0] CLR_MASK = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!rst_n) r_q <= '0;
        else if (i_en) r_q <= i_clr ? (i_d & ~CLR_MASK) : i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MIPS MEM stage - EX/MEM register, data-memory drive with load-to-store forward, MEM/WB register.
// Ports: clk, rst_n (sync, active low), bus (mem_stage_pipe_if.slave).
// Optional macro MEM_STALL_EN adds bus.MEMstall: both registers hold and DMwe is masked while stalled.
module mem_stage_pipe
    import mem_stage_pipe_pkg::*;
(
    input logic clk,
    input logic rst_n,
    mem_stage_pipe_if.slave bus
);
    logic w_en, w_zero;
    logic [EM_W-1:0] w_em_d, w_em_q;
    logic [MW_W-1:0] w_mw_d, w_mw_q;
`ifdef MEM_STALL_EN
    assign w_en = ~bus.MEMstall;
`else
    assign w_en = 1'b1;
`endif
    // writes to $0 never reach WB; the store path keeps its MemWrite
    assign w_zero = bus.EXregwraddr == REG_ZERO;
    assign w_em_d = {bus.EXMemWrite, bus.EXMemtoReg & ~w_zero, bus.EXRegWrite & ~w_zero,
                     bus.EXregwraddr, bus.EXaluout, bus.EXwrdata};
    // stall disables the register entirely, so a flush during stall is dropped
    pipe_reg #(.W(EM_W), .CLR_MASK(EM_CTRL)) u_ex_mem (
        .clk(clk), .rst_n(rst_n), .i_en(w_en), .i_clr(bus.EXflush), .i_d(w_em_d), .o_q(w_em_q)
    );
    assign w_mw_d = {w_em_q[EM_M2R], w_em_q[EM_RW], w_em_q[EM_RD +: REG_AW],
                     w_em_q[EM_ALU +: DATA_W], bus.DMrddata};
    pipe_reg #(.W(MW_W), .CLR_MASK('0)) u_mem_wb (
        .clk(clk), .rst_n(rst_n), .i_en(w_en), .i_clr(1'b0), .i_d(w_mw_d), .o_q(w_mw_q)
    );
    assign bus.DMaddr       = w_em_q[EM_ALU +: DATA_W];
    assign bus.DMwrdata     = bus.pre_lw_and_curr_sw ? w_mw_q[MW_RDD +: DATA_W] : w_em_q[EM_WD +: DATA_W];
    assign bus.DMwe         = w_em_q[EM_MW] & w_en;
    assign bus.MEMMemWrite  = w_em_q[EM_MW];
    assign bus.MEMregwraddr = w_em_q[EM_RD +: REG_AW];
    assign bus.WBMemtoReg   = w_mw_q[MW_M2R];
    assign bus.WBRegWrite   = w_mw_q[MW_RW];
    assign bus.WBregwraddr  = w_mw_q[MW_RD +: REG_AW];
    assign bus.WBmemrddata  = w_mw_q[MW_RDD +: DATA_W];
    assign bus.WBaluout     = w_mw_q[MW_ALU +: DATA_W];
    assign bus.WBwrbackdata = w_mw_q[MW_M2R] ? w_mw_q[MW_RDD +: DATA_W] : w_mw_q[MW_ALU +: DATA_W];
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed scoreboard bench for mem_stage_pipe; define MEM_STALL_EN to cover the stall feature.
module tb_mem_stage_pipe;
    typedef struct {
        int cyc;
        int sel;
        logic [31:0] exp;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    item_t q[$];
    string names[11] = '{"DMaddr", "DMwrdata", "DMwe", "MEMMemWrite", "MEMregwraddr", "WBMemtoReg",
                         "WBRegWrite", "WBregwraddr", "WBmemrddata", "WBaluout", "WBwrbackdata"};

    mem_stage_pipe_if bus();
    mem_stage_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(int s);
        case (s)
            0: return bus.DMaddr;
            1: return bus.DMwrdata;
            2: return 32'(bus.DMwe);
            3: return 32'(bus.MEMMemWrite);
            4: return 32'(bus.MEMregwraddr);
            5: return 32'(bus.WBMemtoReg);
            6: return 32'(bus.WBRegWrite);
            7: return 32'(bus.WBregwraddr);
            8: return bus.WBmemrddata;
            9: return bus.WBaluout;
            10: return bus.WBwrbackdata;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // expect output s to equal v, d cycles after the current one
    task automatic chk(input int d, input int s, input logic [31:0] v);
        item_t it;
        it.cyc = cyc + d;
        it.sel = s;
        it.exp = v;
        q.push_back(it);
    endtask

    task automatic step(input logic rst, fl, mw, m2r, rw, input logic [4:0] rd,
                        input logic [31:0] alu, wd, input logic fwd, input logic [31:0] rdd, input logic st);
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.EXflush = fl;
        bus.EXMemWrite = mw;
        bus.EXMemtoReg = m2r;
        bus.EXRegWrite = rw;
        bus.EXregwraddr = rd;
        bus.EXaluout = alu;
        bus.EXwrdata = wd;
        bus.pre_lw_and_curr_sw = fwd;
        bus.DMrddata = rdd;
`ifdef MEM_STALL_EN
        bus.MEMstall = st;
`else
        if (st) $display("note: stall requested without MEM_STALL_EN");
`endif
    endtask

    // monitor: compare every expectation due this cycle away from the clock edge
    initial begin
        forever begin
            @(negedge clk);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    n_chk++;
                    if (q[i].cyc < cyc || get(q[i].sel) !== q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s cycle %0d: got %h, expected %h", names[q[i].sel], q[i].cyc,
                                 get(q[i].sel), q[i].exp);
                    end
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.EXflush = 0; bus.EXMemWrite = 0; bus.EXMemtoReg = 0; bus.EXRegWrite = 0;
        bus.EXregwraddr = 0; bus.EXaluout = 0; bus.EXwrdata = 0;
        bus.pre_lw_and_curr_sw = 0; bus.DMrddata = 0;
`ifdef MEM_STALL_EN
        bus.MEMstall = 0;
`endif
        // reset with busy inputs for two edges
        step(0, 0, 1, 1, 1, 9, 32'hAAAA, 32'hBBBB, 1, 32'hCCCC, 0);
        for (int s = 0; s < 11; s++) chk(0, s, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < 11; s++) chk(0, s, 0);
        // ALU op to $3
        step(1, 0, 0, 0, 1, 3, 32'h10, 32'h55, 0, 0, 0);
        chk(1, 0, 32'h10); chk(1, 4, 3); chk(1, 2, 0);
        chk(2, 9, 32'h10); chk(2, 6, 1); chk(2, 7, 3); chk(2, 10, 32'h10); chk(2, 5, 0);
        // lw $5
        step(1, 0, 0, 1, 1, 5, 32'h100, 0, 0, 32'h1234, 0);
        chk(1, 8, 32'h1234); chk(1, 0, 32'h100); chk(1, 2, 0);
        // sw $5 with WB load forwarded
        step(1, 0, 1, 0, 0, 5, 32'h104, 32'h1111, 0, 32'hDEADBEEF, 0);
        chk(1, 0, 32'h104); chk(1, 1, 32'hDEADBEEF); chk(1, 2, 1); chk(1, 5, 1); chk(1, 7, 5);
        chk(1, 10, 32'hDEADBEEF); chk(1, 8, 32'hDEADBEEF);
        // sw without forward
        step(1, 0, 1, 0, 0, 6, 32'h108, 32'h2222, 1, 0, 0);
        chk(1, 1, 32'h2222); chk(1, 3, 1);
        // flushed store
        step(1, 1, 1, 1, 1, 7, 32'h40, 32'h99, 0, 0, 0);
        chk(1, 2, 0); chk(1, 3, 0); chk(2, 6, 0); chk(2, 5, 0);
        // load-type write to $0
        step(1, 0, 0, 1, 1, 0, 32'h77, 0, 0, 0, 0);
        chk(2, 6, 0); chk(2, 5, 0); chk(2, 10, 32'h77);
        // store with rt = $0 still writes
        step(1, 0, 1, 0, 0, 0, 32'h80, 32'h5A5A, 0, 0, 0);
        chk(1, 2, 1); chk(1, 1, 32'h5A5A);
        // reset drops an incoming store
        step(0, 0, 1, 0, 1, 2, 32'h90, 32'h6, 0, 0, 0);
        chk(1, 2, 0); chk(1, 3, 0); chk(1, 6, 0); chk(1, 9, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_STALL_EN
        step(1, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 32'h200, 32'hABCD, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, 0, 1, 9, 32'h300, 0, 0, 0, 1);
            chk(0, 2, 0); chk(0, 3, 1); chk(0, 0, 32'h200); chk(0, 9, 32'h44);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk(0, 2, 1); chk(0, 1, 32'hABCD); chk(0, 0, 32'h200);
        chk(1, 2, 0); chk(1, 9, 32'h200);
`endif
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail += q.size();
            $display("FAIL scoreboard drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
